// File: rtl/axi2lint_pkg.sv
// Shared types and constants for the AXI-to-LINT write path.
//   state_t  : split FSM states (IDLE, HIGH)
//   LINT_DW  : LINT data width (32)
//   LINT_BEW : LINT byte-enable width (4)
//   axi_resp_t : AXI response encoding used by the write controllers
package axi2lint_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  localparam int LINT_DW  = 32;
  localparam int LINT_BEW = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

endpackage

// File: rtl/lint_outstanding_cnt.sv
// Up/down saturating counter of LINT writes granted but not yet acknowledged.
// Ports:
//   clk, rst : clock, async active-high reset
//   inc      : a LINT request was granted this cycle
//   dec      : a LINT r_valid arrived this cycle
//   cnt      : current outstanding count
//   full     : cnt >= MAX (no new beat may start)
//   empty    : cnt == 0
module lint_outstanding_cnt #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  // Simultaneous inc/dec cancel; a stray dec at zero is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (inc && !dec)             cnt <= cnt + CW'(1);
    else if (!inc && dec && !empty)   cnt <= cnt - CW'(1);
  end

  assign empty = (cnt == '0);
  assign full  = (cnt >= CW'(MAX));

endmodule

// File: rtl/axi_write_lint_port.sv
// Converts the AXI write controller's memory-port request into 32-bit LINT
// write transactions. A 64-bit beat is split into low then high halves; the
// upstream grant is returned only when the last issued half is granted.
// Outstanding LINT writes are tracked until r_valid for response ordering.
// Optional build macro: LINT_WR_SKIP_ZERO_BE_EN -- halves with an all-zero
// byte enable are not issued on LINT.
// Ports:
//   clk, rst        : clock, async active-high reset
//   valid_i/grant_o : upstream handshake
//   MEM_*           : upstream request (CEN/WEN active low, byte address)
//   MEM_Q_o         : read data, tied 0
//   data_*          : LINT master port
//   idle_o          : no split in flight and nothing outstanding
module axi_write_lint_port
  import axi2lint_pkg::*;
#(
  parameter int                         AXI4_WDATA_WIDTH = 64,
  parameter int                         AXI_NUMBYTES     = AXI4_WDATA_WIDTH / 8,
  parameter int                         MEM_ADDR_WIDTH   = 13,
  parameter int                         LINT_ADDR_WIDTH  = 32,
  parameter logic [LINT_ADDR_WIDTH-1:0] LINT_BASE_ADDR   = 32'h1C00_0000,
  parameter int                         MAX_OUTSTANDING  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  output logic                        grant_o,
  input  logic                        MEM_CEN_i,
  input  logic                        MEM_WEN_i,
  input  logic [MEM_ADDR_WIDTH-1:0]   MEM_A_i,
  input  logic [AXI4_WDATA_WIDTH-1:0] MEM_D_i,
  input  logic [AXI_NUMBYTES-1:0]     MEM_BE_i,
  input  logic                        MEM_size_i,
  output logic [AXI4_WDATA_WIDTH-1:0] MEM_Q_o,
  output logic                        data_req_o,
  output logic [LINT_ADDR_WIDTH-1:0]  data_add_o,
  output logic                        data_wen_o,
  output logic [LINT_DW-1:0]          data_wdata_o,
  output logic [LINT_BEW-1:0]         data_be_o,
  input  logic                        data_gnt_i,
  input  logic                        data_r_valid_i,
  output logic                        idle_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 2);

  state_t               state_q, state_d;
  logic [LINT_DW-1:0]   hi_data_q;
  logic [LINT_BEW-1:0]  hi_be_q;
  logic                 hi_wen_q;
  logic                 ld_hi;

  logic [CW-1:0]        cnt;
  logic                 full, empty;

  logic [LINT_ADDR_WIDTH-1:0] base, base_hi;
  logic [LINT_DW-1:0]   d_lo, d_hi;
  logic [LINT_BEW-1:0]  be_lo, be_hi;
  logic                 lane, beat_v, req, skip_lo, skip_hi;
  logic                 req_c, grant_c, wen_c;
  logic [LINT_ADDR_WIDTH-1:0] add_c;
  logic [LINT_DW-1:0]   wdata_c;
  logic [LINT_BEW-1:0]  be_c;
  logic                 unused_a;

  assign base    = LINT_BASE_ADDR | LINT_ADDR_WIDTH'({MEM_A_i[MEM_ADDR_WIDTH-1:3], 3'b000});
  assign base_hi = base + LINT_ADDR_WIDTH'(4);
  assign d_lo    = MEM_D_i[31:0];
  assign d_hi    = MEM_D_i[63:32];
  assign be_lo   = MEM_BE_i[3:0];
  assign be_hi   = MEM_BE_i[7:4];
  assign lane    = MEM_A_i[2];
  assign unused_a = ^MEM_A_i[1:0];

  assign beat_v = valid_i & ~MEM_CEN_i;
  assign req    = beat_v & ~full;

`ifdef LINT_WR_SKIP_ZERO_BE_EN
  assign skip_lo = (be_lo == '0);
  assign skip_hi = (be_hi == '0);
`else
  assign skip_lo = 1'b0;
  assign skip_hi = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_data_q <= '0;
      hi_be_q   <= '0;
      hi_wen_q  <= 1'b0;
    end else if (ld_hi) begin
      hi_data_q <= d_hi;
      hi_be_q   <= be_hi;
      hi_wen_q  <= MEM_WEN_i;
    end
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    grant_c = 1'b0;
    ld_hi   = 1'b0;
    add_c   = base;
    wdata_c = d_lo;
    be_c    = be_lo;
    wen_c   = MEM_WEN_i;
    case (state_q)
      IDLE: begin
        if (!MEM_size_i) begin
          add_c   = lane ? base_hi : base;
          wdata_c = lane ? d_hi : d_lo;
          be_c    = lane ? be_hi : be_lo;
          if (lane ? skip_hi : skip_lo) grant_c = beat_v;
          else begin
            req_c   = req;
            grant_c = req & data_gnt_i;
          end
        end else if (skip_lo && skip_hi) begin
          grant_c = beat_v;
        end else if (skip_lo) begin
          // Only the high half carries bytes: issue it directly from the inputs.
          add_c   = base_hi;
          wdata_c = d_hi;
          be_c    = be_hi;
          req_c   = req;
          grant_c = req & data_gnt_i;
        end else begin
          req_c = req;
          if (req && data_gnt_i) begin
            if (skip_hi) grant_c = 1'b1;
            else begin
              ld_hi   = 1'b1;
              state_d = HIGH;
            end
          end
        end
      end
      HIGH: begin
        // Count limit deliberately not rechecked: the split must finish.
        req_c   = 1'b1;
        add_c   = base_hi;
        wdata_c = hi_data_q;
        be_c    = hi_be_q;
        wen_c   = hi_wen_q;
        if (data_gnt_i) begin
          grant_c = valid_i;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate with rst so the request drops the moment reset is applied.
  assign data_req_o   = req_c & ~rst;
  assign grant_o      = grant_c & ~rst;
  assign data_add_o   = add_c;
  assign data_wdata_o = wdata_c;
  assign data_be_o    = be_c;
  assign data_wen_o   = wen_c;
  assign MEM_Q_o      = '0;
  assign idle_o       = (state_q == IDLE) & empty;

  lint_outstanding_cnt #(
    .MAX (MAX_OUTSTANDING),
    .CW  (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (data_req_o & data_gnt_i),
    .dec   (data_r_valid_i),
    .cnt   (cnt),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_axi_write_lint_port.sv
module tb_axi_write_lint_port;
  localparam int          MAXO = 4;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, grant_o, MEM_CEN_i, MEM_WEN_i, MEM_size_i;
  logic [12:0] MEM_A_i;
  logic [63:0] MEM_D_i, MEM_Q_o;
  logic [7:0]  MEM_BE_i;
  logic        data_req_o, data_wen_o, data_gnt_i, data_r_valid_i, idle_o;
  logic [31:0] data_add_o, data_wdata_o;
  logic [3:0]  data_be_o;

  int errors = 0;
  int checks = 0;
  int cnt_m  = 0;   // model: outstanding LINT writes

  always #5 clk = ~clk;

  axi_write_lint_port dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .grant_o(grant_o),
    .MEM_CEN_i(MEM_CEN_i), .MEM_WEN_i(MEM_WEN_i), .MEM_A_i(MEM_A_i),
    .MEM_D_i(MEM_D_i), .MEM_BE_i(MEM_BE_i), .MEM_size_i(MEM_size_i),
    .MEM_Q_o(MEM_Q_o), .data_req_o(data_req_o), .data_add_o(data_add_o),
    .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
    .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i), .idle_o(idle_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit issued(input logic [3:0] b);
`ifdef LINT_WR_SKIP_ZERO_BE_EN
    return b != 4'h0;
`else
    return 1'b1;
`endif
  endfunction

  // Cycle convention: tasks are entered 1 time unit after a rising edge.
  task automatic drive(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be,
                       input logic sz, input logic wen);
    valid_i = 1'b1; MEM_CEN_i = 1'b0; MEM_A_i = a; MEM_D_i = d;
    MEM_BE_i = be; MEM_size_i = sz; MEM_WEN_i = wen;
  endtask

  task automatic chk_idle(input string tag);
    #1 chk(tag, {63'd0, idle_o}, {63'd0, cnt_m == 0});
  endtask

  // Reference: list the 32-bit halves the beat must produce, then walk them.
  task automatic do_beat(input string tag, input logic [12:0] a, input logic [63:0] d,
                         input logic [7:0] be, input logic sz, input logic wen,
                         input int dly, input bit rv_last);
    logic [31:0] base, ea[2], ed[2];
    logic [3:0]  eb[2];
    int n = 0;
    base = BASE | {19'd0, a[12:3], 3'b000};
    if (!sz) begin
      if (issued(a[2] ? be[7:4] : be[3:0])) begin
        ea[0] = base + (a[2] ? 32'd4 : 32'd0);
        ed[0] = a[2] ? d[63:32] : d[31:0];
        eb[0] = a[2] ? be[7:4] : be[3:0];
        n = 1;
      end
    end else begin
      if (issued(be[3:0])) begin ea[n] = base; ed[n] = d[31:0]; eb[n] = be[3:0]; n++; end
      if (issued(be[7:4])) begin ea[n] = base + 32'd4; ed[n] = d[63:32]; eb[n] = be[7:4]; n++; end
    end
    drive(a, d, be, sz, wen);
    if (n == 0) begin
      data_gnt_i = 1'b0;
      #1;
      chk({tag, ".nogrant"}, {63'd0, grant_o}, 64'd1);
      chk({tag, ".noreq"}, {63'd0, data_req_o}, 64'd0);
      @(posedge clk); #1;
    end
    for (int h = 0; h < n; h++) begin
      for (int w = 0; w <= dly; w++) begin
        data_gnt_i     = (w == dly);
        data_r_valid_i = (w == dly) && rv_last && (h == n - 1);
        #1;
        chk({tag, ".req"},   {63'd0, data_req_o}, 64'd1);
        chk({tag, ".add"},   {32'd0, data_add_o}, {32'd0, ea[h]});
        chk({tag, ".wdata"}, {32'd0, data_wdata_o}, {32'd0, ed[h]});
        chk({tag, ".be"},    {60'd0, data_be_o}, {60'd0, eb[h]});
        chk({tag, ".wen"},   {63'd0, data_wen_o}, {63'd0, wen});
        chk({tag, ".grant"}, {63'd0, grant_o}, {63'd0, (w == dly) && (h == n - 1)});
        chk({tag, ".q"},     MEM_Q_o, 64'd0);
        @(posedge clk);
        if (w == dly && !data_r_valid_i) cnt_m++;
        #1;
      end
    end
    data_gnt_i = 1'b0; data_r_valid_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic ack(input int n);
    valid_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_r_valid_i = 1'b1;
      @(posedge clk);
      if (cnt_m > 0) cnt_m--;
      #1;
    end
    data_r_valid_i = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic [12:0] a;
    rst = 1'b1; valid_i = 1'b0; MEM_CEN_i = 1'b1; MEM_WEN_i = 1'b0; MEM_A_i = '0;
    MEM_D_i = '0; MEM_BE_i = '0; MEM_size_i = 1'b0; data_gnt_i = 1'b0; data_r_valid_i = 1'b0;
    #1;
    chk("rst.req",   {63'd0, data_req_o}, 64'd0);
    chk("rst.grant", {63'd0, grant_o}, 64'd0);
    chk("rst.idle",  {63'd0, idle_o}, 64'd1);
    chk("rst.q",     MEM_Q_o, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // CEN high: nothing happens
    drive(13'h0040, 64'h1, 8'hFF, 1'b0, 1'b0);
    MEM_CEN_i = 1'b1;
    #1 chk("cen.req", {63'd0, data_req_o}, 64'd0);
    @(posedge clk); #1; valid_i = 1'b0;

    // 32-bit beat, upper lane
    do_beat("w32", 13'h0104, 64'hAABBCCDD_11223344, 8'hF0, 1'b0, 1'b0, 0, 1'b0);
    chk_idle("w32.idle");
    ack(1);
    chk_idle("w32.ackidle");

    // 64-bit beat, 2-cycle grant delay per half
    do_beat("w64", 13'h0200, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b0, 2, 1'b0);
    ack(2);
    chk_idle("w64.idle");

    // Fill to MAX_OUTSTANDING, then the next beat must stall
    for (int i = 0; i < MAXO; i++)
      do_beat("fill", 13'(i * 4), {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
    a = 13'h0ABC; d = {$urandom, $urandom};
    drive(a, d, 8'hFF, 1'b0, 1'b0);
    #1;
    chk("full.req",   {63'd0, data_req_o}, 64'd0);
    chk("full.grant", {63'd0, grant_o}, 64'd0);
    chk("full.idle",  {63'd0, idle_o}, 64'd0);
    @(posedge clk); #1;
    data_r_valid_i = 1'b1;
    #1 chk("full.rvcyc", {63'd0, data_req_o}, 64'd0);
    @(posedge clk); cnt_m--; #1;
    data_r_valid_i = 1'b0;
    do_beat("unstall", a, d, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < MAXO; i++) begin
      chk_idle("drain.idle");
      ack(1);
    end
    chk_idle("drain.final");

    // Grant and r_valid together at count 2
    do_beat("sim0", 13'h0010, 64'h11, 8'h0F, 1'b0, 1'b0, 0, 1'b0);
    do_beat("sim1", 13'h0014, 64'h22_0000_0000, 8'hF0, 1'b0, 1'b0, 0, 1'b0);
    do_beat("sim2", 13'h0018, 64'h33, 8'h0F, 1'b0, 1'b0, 0, 1'b1);
    do_beat("sim3", 13'h0020, 64'h44, 8'h0F, 1'b0, 1'b0, 0, 1'b0);
    do_beat("sim4", 13'h0024, 64'h55_0000_0000, 8'hF0, 1'b0, 1'b0, 0, 1'b0);
    drive(13'h0030, 64'h66, 8'h0F, 1'b0, 1'b0);
    #1 chk("sim.full", {63'd0, data_req_o}, 64'd0);
    @(posedge clk); #1;
    ack(3);
    chk_idle("sim.ack3");
    ack(1);
    chk_idle("sim.ack4");

    // r_valid at count 0 must not wrap the counter
    ack(2);
    do_beat("sat", 13'h0040, 64'h77, 8'h0F, 1'b0, 1'b0, 0, 1'b0);
    chk_idle("sat.idle");
    ack(1);

    // Reset while waiting for the high-half grant
    a = 13'h0300; d = 64'hDEAD_BEEF_CAFE_F00D;
    drive(a, d, 8'hFF, 1'b1, 1'b0);
    data_gnt_i = 1'b1;
    #1 chk("rsth.lo", {32'd0, data_add_o}, {32'd0, BASE | 32'h300});
    @(posedge clk); #1;
    data_gnt_i = 1'b0;
    #1 chk("rsth.hi", {32'd0, data_add_o}, {32'd0, BASE | 32'h304});
    rst = 1'b1;
    #1;
    chk("rsth.req",  {63'd0, data_req_o}, 64'd0);
    chk("rsth.idle", {63'd0, idle_o}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; cnt_m = 0;
    do_beat("rsth.again", a, d, 8'hFF, 1'b1, 1'b0, 1, 1'b0);
    ack(2);
    chk_idle("rsth.done");

    // Randomized beats, including reads and BE patterns
    for (int i = 0; i < 40; i++) begin
      while (cnt_m >= MAXO) ack(1);
      if ($urandom_range(0, 2) == 0) ack($urandom_range(1, 2));
      do_beat("rnd", 13'($urandom), {$urandom, $urandom}, 8'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end
    ack(cnt_m);
    chk_idle("rnd.idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
